// File: rtl/sig_change_logger.sv
// Change-driven event logger: records {timestamp, a, b, i_val==j_val} into a FWFT FIFO whenever the sampled tuple changes.
// Optional drop counter built only when SIG_CHANGE_LOGGER_DROP_CNT_EN is defined; otherwise drop_cnt is tied to 0.
module sig_change_logger #(
  parameter int DATA_W = 32,
  parameter int TS_W   = 16,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     smp_en,
  input  logic                     a,
  input  logic                     b,
  input  logic [DATA_W-1:0]        i_val,
  input  logic [DATA_W-1:0]        j_val,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [TS_W-1:0]          evt_ts,
  output logic                     evt_a,
  output logic                     evt_b,
  output logic                     evt_eq,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [7:0]               drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef struct packed {
    logic [TS_W-1:0] ts;
    logic            a;
    logic            b;
    logic            eq;
  } rec_t;

  rec_t            mem [DEPTH];
  rec_t            head;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [LW-1:0]   count;
  logic [TS_W-1:0] ts_cnt;
  logic            first;
  logic [2:0]      last_tup;

  logic            eq;
  logic [2:0]      tup;
  logic            gen;
  logic            full;
  logic            pop;
  logic            push;

  assign eq   = (i_val == j_val);
  assign tup  = {a, b, eq};
  assign gen  = smp_en && (first || (tup != last_tup));
  assign full = (count == LW'(DEPTH));
  assign pop  = evt_valid && evt_ready;
  // A full FIFO still takes the new record when the head leaves in the same cycle.
  assign push = gen && (!full || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_cnt   <= '0;
      first    <= 1'b1;
      last_tup <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register reading pre-edge values, independent of statement order.
      ts_cnt <= ts_cnt + TS_W'(1);
      if (gen) begin
        first    <= 1'b0;
        last_tup <= tup;
      end
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: record storage has no reset; emptiness is tracked by count and the head fields are masked while empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{ts: ts_cnt, a: a, b: b, eq: eq};
  end

  assign head       = mem[rd_ptr];
  assign evt_valid  = (count != '0);
  assign evt_ts     = evt_valid ? head.ts : '0;
  assign evt_a      = evt_valid && head.a;
  assign evt_b      = evt_valid && head.b;
  assign evt_eq     = evt_valid && head.eq;
  assign fifo_level = count;

`ifdef SIG_CHANGE_LOGGER_DROP_CNT_EN
  logic [7:0] drop_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q <= '0;
    end else if (gen && !push && (drop_q != 8'hFF)) begin
      drop_q <= drop_q + 8'd1;
    end
  end

  assign drop_cnt = drop_q;
`else
  assign drop_cnt = '0;
`endif

endmodule
